// File: rtl/jk_excitation_driver.sv
// Drives J/K excitation into an external bank of JK flip-flops to move it to a requested state,
// keeping a shadow of the bank and checking the readback one cycle after each drive.
module jk_excitation_driver #(
   parameter int WIDTH      = 4,
   parameter bit USE_TOGGLE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   input  logic             clr_req,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic             jk_rst,
   input  logic [WIDTH-1:0] q_fb,
   output logic             done,
   output logic             err,
   input  logic             err_clr
);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_DRIVE = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   // Changing bits either toggle, or are set/reset explicitly towards the target value.
   function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] t);
      logic [WIDTH-1:0] diff;
      logic [WIDTH-1:0] jv;
      logic [WIDTH-1:0] kv;
      diff = s ^ t;
      if (USE_TOGGLE) begin
         jv = diff;
         kv = diff;
      end else begin
         jv = diff & t;
         kv = diff & s;
      end
      return {jv, kv};
   endfunction

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      j_d      = '0;
      k_d      = '0;
      ready_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      case (state_q)
         S_CLEAR: begin
            shadow_d = '0;
            state_d  = S_CHECK;
            done_d   = 1'b1;
         end
         S_IDLE: begin
            if (clr_req) begin
               state_d = S_CLEAR;
            end else if (tgt_valid) begin
               shadow_d   = tgt_data;
               {j_d, k_d} = excite(shadow_q, tgt_data);
               state_d    = S_DRIVE;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_DRIVE: begin
            state_d = S_CHECK;
            done_d  = 1'b1;
         end
         S_CHECK: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
      // A mismatch seen in the same cycle as err_clr wins, so no error can be lost.
      if ((state_q == S_CHECK) && (q_fb != shadow_q)) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_CLEAR;
         shadow_q <= '0;
         j_q      <= '0;
         k_q      <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         j_q      <= j_d;
         k_q      <= k_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Gating with rst_n keeps the bank reset quiet while held in reset, so it lasts exactly one cycle.
   assign jk_rst    = (state_q == S_CLEAR) && rst_n;
   assign tgt_ready = ready_q;
   assign jk_j      = j_q;
   assign jk_k      = k_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: two drivers (set/reset and toggle flavours) each steer their own JK bank model
// from the same stimulus; expected excitation and readback are queued at issue and checked on done.
module tb_jk_excitation_driver;

   typedef struct {
      logic [3:0] jSet;
      logic [3:0] kSet;
      logic [3:0] jTog;
      logic [3:0] kTog;
      logic [3:0] q;
      logic       rst;
      logic [3:0] mask;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tgtValid = 1'b0;
   logic [3:0] tgtData = '0;
   logic       clrReq = 1'b0;
   logic       errClr = 1'b0;
   logic [3:0] fbMask = '0;

   logic       readySet, readyTog, jkRstSet, jkRstTog;
   logic       doneSet, doneTog, errSet, errTog;
   logic [3:0] jSet, kSet, jTog, kTog;
   logic [3:0] bankSet = 4'b1111;
   logic [3:0] bankTog = 4'b1011;
   logic [3:0] qFbSet, qFbTog;

   int         errors = 0;
   int         checks = 0;
   expect_t    sb[$];
   logic [3:0] modelShadow = '0;
   logic       expErr = 1'b0;
   logic       checkNow = 1'b0;
   logic       mismatchNow = 1'b0;

   logic [3:0] prevJSet = '0, prevKSet = '0, prevJTog = '0, prevKTog = '0;
   logic       prevRstSet = 1'b0, prevRstTog = 1'b0;

   always #5 clk = ~clk;

   jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1'b0)) dutSet (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgtValid), .tgt_data(tgtData),
      .tgt_ready(readySet), .clr_req(clrReq), .jk_j(jSet), .jk_k(kSet),
      .jk_rst(jkRstSet), .q_fb(qFbSet), .done(doneSet), .err(errSet), .err_clr(errClr)
   );

   jk_excitation_driver #(.WIDTH(4), .USE_TOGGLE(1'b1)) dutTog (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgtValid), .tgt_data(tgtData),
      .tgt_ready(readyTog), .clr_req(clrReq), .jk_j(jTog), .jk_k(kTog),
      .jk_rst(jkRstTog), .q_fb(qFbTog), .done(doneTog), .err(errTog), .err_clr(errClr)
   );

   // JK bank models: synchronous active-high reset, then Q+ = J&~Q | ~K&Q.
   always @(posedge clk) begin
      bankSet <= jkRstSet ? 4'b0000 : ((jSet & ~bankSet) | (~kSet & bankSet));
      bankTog <= jkRstTog ? 4'b0000 : ((jTog & ~bankTog) | (~kTog & bankTog));
   end
   assign qFbSet = bankSet ^ fbMask;
   assign qFbTog = bankTog ^ fbMask;

   task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: for each bit, hold if unchanged, else set/reset (or toggle in toggle mode).
   function automatic void excitation(input logic [3:0] s, input logic [3:0] t, input bit toggle,
                                      output logic [3:0] j, output logic [3:0] k);
      j = '0;
      k = '0;
      for (int i = 0; i < 4; i++) begin
         if (s[i] != t[i]) begin
            if (toggle) begin
               j[i] = 1'b1;
               k[i] = 1'b1;
            end else if (t[i]) begin
               j[i] = 1'b1;
            end else begin
               k[i] = 1'b1;
            end
         end
      end
   endfunction

   function automatic expect_t clearEntry();
      expect_t e;
      e.jSet = '0; e.kSet = '0; e.jTog = '0; e.kTog = '0;
      e.q = '0; e.rst = 1'b1; e.mask = '0;
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) expErr = 1'b0;
      else if (checkNow && mismatchNow) expErr = 1'b1;
      else if (errClr) expErr = 1'b0;
   end

   // Monitor: pops one expectation per done pulse; excitation is compared from the preceding cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         expect_t e;
         checkNow = 1'b0;
         if (doneSet || doneTog) begin
            checkOutput("doneAgree", {3'b0, doneTog}, {3'b0, doneSet});
            if (sb.size() == 0) begin
               checkOutput("unexpectedDone", 4'd1, 4'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("jSet", prevJSet, e.jSet);
               checkOutput("kSet", prevKSet, e.kSet);
               checkOutput("jTog", prevJTog, e.jTog);
               checkOutput("kTog", prevKTog, e.kTog);
               checkOutput("bankRstSet", {3'b0, prevRstSet}, {3'b0, e.rst});
               checkOutput("bankRstTog", {3'b0, prevRstTog}, {3'b0, e.rst});
               checkOutput("qFbSet", qFbSet, e.q);
               checkOutput("qFbTog", qFbTog, e.q);
               checkNow    = 1'b1;
               mismatchNow = (e.mask != 4'b0000);
            end
         end
         if (readySet) begin
            checkOutput("idleReadyTog", {3'b0, readyTog}, 4'd1);
            checkOutput("idleHold", {jSet | kSet | jTog | kTog}, 4'b0000);
            checkOutput("idleBankRst", {2'b0, jkRstSet, jkRstTog}, 4'b0000);
         end
         checkOutput("errSet", {3'b0, errSet}, {3'b0, expErr});
         checkOutput("errTog", {3'b0, errTog}, {3'b0, expErr});
      end
      prevJSet = jSet; prevKSet = kSet; prevJTog = jTog; prevKTog = kTog;
      prevRstSet = jkRstSet; prevRstTog = jkRstTog;
   end

   task automatic waitReady();
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (readySet) seen = 1'b1;
      end
      if (!seen) checkOutput("readyTimeout", 4'd0, 4'd1);
   endtask

   task automatic applyStimulus(input logic [3:0] t, input logic [3:0] mask, input bit holdClr);
      expect_t e;
      waitReady();
      excitation(modelShadow, t, 1'b0, e.jSet, e.kSet);
      excitation(modelShadow, t, 1'b1, e.jTog, e.kTog);
      e.q = t ^ mask; e.rst = 1'b0; e.mask = mask;
      sb.push_back(e);
      modelShadow = t;
      tgtData  = t;
      tgtValid = 1'b1;
      fbMask   = mask;
      errClr   = holdClr;
      @(posedge clk); #1;
      tgtValid = 1'b0;
      if (holdClr) begin
         repeat (2) @(posedge clk);
         #1 errClr = 1'b0;
      end
   endtask

   task automatic clearErr();
      waitReady();
      errClr = 1'b1;
      @(posedge clk); #1;
      errClr = 1'b0;
   endtask

   task automatic clearWithTarget(input logic [3:0] t);
      waitReady();
      tgtData  = t;
      tgtValid = 1'b1;
      clrReq   = 1'b1;
      fbMask   = '0;
      sb.push_back(clearEntry());
      modelShadow = '0;
      @(posedge clk); #1;
      clrReq = 1'b0;
      @(negedge clk);
      checkOutput("clrReadyLow1", {3'b0, readySet}, 4'd0);
      @(negedge clk);
      checkOutput("clrReadyLow2", {3'b0, readySet}, 4'd0);
      applyStimulus(t, 4'b0000, 1'b0);
   endtask

   task automatic resetInDrive();
      waitReady();
      tgtData  = ~modelShadow;
      tgtValid = 1'b1;
      @(posedge clk); #1;
      tgtValid = 1'b0;
      @(negedge clk);
      checkOutput("driveActive", jSet | kSet, 4'b1111);
      rst_n = 1'b0;
      #1;
      checkOutput("rstJkSet", jSet | kSet, 4'b0000);
      checkOutput("rstJkTog", jTog | kTog, 4'b0000);
      checkOutput("rstOutputs", {doneSet, readySet, errSet, jkRstSet}, 4'b0000);
      fbMask = '0;
      sb.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      sb.push_back(clearEntry());
      modelShadow = '0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] t;
      logic [3:0] mask;
      sb.push_back(clearEntry());
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetOutputs", {doneSet, readySet, errSet, jkRstSet}, 4'b0000);
      checkOutput("resetJk", jSet | kSet | jTog | kTog, 4'b0000);
      #1 rst_n = 1'b1;

      applyStimulus(4'b1010, 4'b0000, 1'b0);
      applyStimulus(4'b0110, 4'b0000, 1'b0);
      applyStimulus(4'b0110, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0110, 4'b0001, 1'b0);
      applyStimulus(4'b1111, 4'b0000, 1'b0);
      clearErr();
      applyStimulus(4'b0011, 4'b0100, 1'b1);
      clearErr();
      clearWithTarget(4'b1001);
      resetInDrive();
      applyStimulus(4'b0101, 4'b0000, 1'b0);

      for (int n = 0; n < 40; n++) begin
         t    = 4'($urandom_range(0, 15));
         mask = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         case ($urandom_range(0, 9))
            0: clearWithTarget(t);
            1: clearErr();
            default: applyStimulus(t, mask, 1'b0);
         endcase
      end

      waitReady();
      repeat (2) @(negedge clk);
      checkOutput("scoreboardDrained", 4'(sb.size()), 4'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
